// File: rtl/updown_counter_n.sv
// WIDTH-bit up/down counter with programmable modulus, wrap or saturate,
// synchronous load, registered carry pulse and sticky overflow.
module updown_counter_n #(
    parameter int          WIDTH     = 8,
    parameter int unsigned MAX_COUNT = 255,
    parameter bit          SATURATE  = 1'b0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             Load,
    input  logic             Up,
    input  logic             ClearOvf,
    input  logic [WIDTH-1:0] Data,
    output logic [WIDTH-1:0] Count,
    output logic             TC,
    output logic             Carry,
    output logic             Overflow
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic             at_top;
    logic             at_zero;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] step_val;

    always_comb begin
        at_top   = (Count == MAX);
        at_zero  = (Count == '0);
        TC       = Up ? at_top : at_zero;
        // Loads above the modulus clamp to the top of the range
        load_val = (Data > MAX) ? MAX : Data;
        step_val = Count;
        if (Up) begin
            if (!at_top)
                step_val = Count + ONE;
            else if (!SATURATE)
                step_val = '0;
        end else begin
            if (!at_zero)
                step_val = Count - ONE;
            else if (!SATURATE)
                step_val = MAX;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            Count    <= '0;
            Carry    <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            Carry <= 1'b0;
            if (ClearOvf)
                Overflow <= 1'b0;
            if (Load) begin
                Count <= load_val;
            end else if (Enable) begin
                Count <= step_val;
                // Boundary set overrides a same-edge clear
                if (TC) begin
                    Carry    <= 1'b1;
                    Overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_updown_counter_n.sv
// Directed scoreboard bench for updown_counter_n over four parameter sets.
// Expectations are queued as stimulus is driven and checked after each edge.
module tb_updown_counter_n;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic       rst [4];
    logic       en  [4];
    logic       ld  [4];
    logic       up  [4];
    logic       clr [4];
    logic [7:0] dat [4];

    logic [7:0] c0, c1, c2;
    logic [3:0] c3;
    logic       tc0, tc1, tc2, tc3;
    logic       ca0, ca1, ca2, ca3;
    logic       ov0, ov1, ov2, ov3;

    int maxv [4] = '{255, 9, 9, 15};

    updown_counter_n #(.WIDTH(8), .MAX_COUNT(255), .SATURATE(1'b0)) u0 (
        .Clock(Clock), .Reset(rst[0]), .Enable(en[0]), .Load(ld[0]),
        .Up(up[0]), .ClearOvf(clr[0]), .Data(dat[0]),
        .Count(c0), .TC(tc0), .Carry(ca0), .Overflow(ov0));

    updown_counter_n #(.WIDTH(8), .MAX_COUNT(9), .SATURATE(1'b0)) u1 (
        .Clock(Clock), .Reset(rst[1]), .Enable(en[1]), .Load(ld[1]),
        .Up(up[1]), .ClearOvf(clr[1]), .Data(dat[1]),
        .Count(c1), .TC(tc1), .Carry(ca1), .Overflow(ov1));

    updown_counter_n #(.WIDTH(8), .MAX_COUNT(9), .SATURATE(1'b1)) u2 (
        .Clock(Clock), .Reset(rst[2]), .Enable(en[2]), .Load(ld[2]),
        .Up(up[2]), .ClearOvf(clr[2]), .Data(dat[2]),
        .Count(c2), .TC(tc2), .Carry(ca2), .Overflow(ov2));

    updown_counter_n #(.WIDTH(4), .MAX_COUNT(15), .SATURATE(1'b0)) u3 (
        .Clock(Clock), .Reset(rst[3]), .Enable(en[3]), .Load(ld[3]),
        .Up(up[3]), .ClearOvf(clr[3]), .Data(dat[3][3:0]),
        .Count(c3), .TC(tc3), .Carry(ca3), .Overflow(ov3));

    typedef struct {
        string      tag;
        int         u;
        logic [7:0] cnt;
        logic       car;
        logic       ovf;
        logic       tc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [10:0] obs(int u);
        case (u)
            0:       return {tc0, ov0, ca0, c0};
            1:       return {tc1, ov1, ca1, c1};
            2:       return {tc2, ov2, ca2, c2};
            default: return {tc3, ov3, ca3, 4'h0, c3};
        endcase
    endfunction

    // TC expectation follows from the direction currently driven
    task automatic push(string tag, int u, int cnt, logic car, logic ovf);
        exp_t e;
        e.tag = tag;
        e.u   = u;
        e.cnt = 8'(cnt);
        e.car = car;
        e.ovf = ovf;
        e.tc  = up[u] ? (cnt == maxv[u]) : (cnt == 0);
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t        e;
        logic [10:0] o;
        logic [10:0] w;
        @(posedge Clock);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.u);
            w = {e.tc, e.ovf, e.car, e.cnt};
            checks++;
            assert (o === w) else begin
                errors++;
                $error("FAIL %s u%0d: got tc/ovf/carry/count=%b/%b/%b/%h want %b/%b/%b/%h",
                       e.tag, e.u, o[10], o[9], o[8], o[7:0],
                       w[10], w[9], w[8], w[7:0]);
            end
        end
    endtask

    task automatic idle_all();
        for (int i = 0; i < 4; i++) begin
            rst[i] = 1'b0;
            en[i]  = 1'b0;
            ld[i]  = 1'b0;
            clr[i] = 1'b0;
        end
    endtask

    initial begin
        int  e3;
        logic o3;

        for (int i = 0; i < 4; i++) begin
            rst[i] = 1'b1;
            en[i]  = 1'b1;
            ld[i]  = 1'b1;
            up[i]  = 1'b1;
            clr[i] = 1'b0;
            dat[i] = 8'h55;
        end
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++)
                push("reset", i, 0, 1'b0, 1'b0);
            tick();
        end
        idle_all();
        for (int i = 0; i < 4; i++)
            push("hold_after_reset", i, 0, 1'b0, 1'b0);
        tick();

        // Up wrap at default modulus
        ld[0] = 1'b1; dat[0] = 8'hFD;
        push("load_fd", 0, 8'hFD, 1'b0, 1'b0); tick();
        ld[0] = 1'b0; en[0] = 1'b1; up[0] = 1'b1;
        push("up_fe", 0, 8'hFE, 1'b0, 1'b0); tick();
        push("up_ff_tc", 0, 8'hFF, 1'b0, 1'b0); tick();
        push("wrap_00", 0, 8'h00, 1'b1, 1'b1); tick();
        push("up_01", 0, 8'h01, 1'b0, 1'b1); tick();
        en[0] = 1'b0;

        // Priority: load over enable, then reset over load
        ld[0] = 1'b1; dat[0] = 8'h20;
        push("load_20", 0, 8'h20, 1'b0, 1'b1); tick();
        en[0] = 1'b1; dat[0] = 8'h10;
        push("load_beats_en", 0, 8'h10, 1'b0, 1'b1); tick();
        ld[0] = 1'b0; up[0] = 1'b0;
        push("down_0f", 0, 8'h0F, 1'b0, 1'b1); tick();
        rst[0] = 1'b1; ld[0] = 1'b1; dat[0] = 8'h33;
        push("reset_beats_load", 0, 0, 1'b0, 1'b0); tick();
        idle_all();

        // Modulus 10, wrapping down
        ld[1] = 1'b1; dat[1] = 8'd1; up[1] = 1'b0;
        push("m9_load1", 1, 1, 1'b0, 1'b0); tick();
        ld[1] = 1'b0; en[1] = 1'b1;
        push("m9_down0", 1, 0, 1'b0, 1'b0); tick();
        push("m9_wrap9", 1, 9, 1'b1, 1'b1); tick();
        push("m9_down8", 1, 8, 1'b0, 1'b1); tick();
        en[1] = 1'b0; ld[1] = 1'b1; dat[1] = 8'd12;
        push("m9_clamp", 1, 9, 1'b0, 1'b1); tick();
        idle_all();

        // Modulus 10, saturating
        ld[2] = 1'b1; dat[2] = 8'd8; up[2] = 1'b1;
        push("sat_load8", 2, 8, 1'b0, 1'b0); tick();
        ld[2] = 1'b0; en[2] = 1'b1;
        push("sat_9", 2, 9, 1'b0, 1'b0); tick();
        push("sat_hold1", 2, 9, 1'b1, 1'b1); tick();
        push("sat_hold2", 2, 9, 1'b1, 1'b1); tick();
        en[2] = 1'b0; clr[2] = 1'b1;
        push("sat_clear", 2, 9, 1'b0, 1'b0); tick();
        en[2] = 1'b1;
        push("set_wins_clear", 2, 9, 1'b1, 1'b1); tick();
        en[2] = 1'b0; clr[2] = 1'b0;
        push("sat_idle", 2, 9, 1'b0, 1'b1); tick();
        idle_all();

        // 4-bit counter, 20 up steps from 0
        en[3] = 1'b1; up[3] = 1'b1;
        e3 = 0;
        o3 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            logic wrapped;
            wrapped = (e3 == 15);
            e3 = (e3 + 1) % 16;
            if (wrapped)
                o3 = 1'b1;
            push("w4_step", 3, e3, wrapped, o3);
            tick();
        end
        en[3] = 1'b0;
        push("w4_final", 3, 4, 1'b0, 1'b1); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
